wb_regfile: RTL and testbench
=============================

// Module: wb_regfile
// PURPOSE
//  Writeback end of the MEM/WB pipeline interface: consumes the WB-stage bundle
//  (RegWriteW, ResultSrcW, ALUResultW, ReadDataW, RdW, PCPlus4W) and selects ResultW.
//  Commits ResultW to a 2-read/1-write architectural register file, bypassing it to
//  the decode-stage read ports. Exports ResultW for EX forwarding; counts committed writes.
// PARAMETERS
//  XLEN   32  data width of registers and result path
//  NREGS  32  number of architectural registers; index width = $clog2(NREGS) = 5
//  CNT_W  32  width of the committed-write counter
// PORTS
//  clock        in   1      clock; all state updates on posedge
//  reset        in   1      reset, asynchronous, active-high
//  RegWriteW    in   1      writeback enable from MEM/WB
//  ResultSrcW   in   2      result select: 00 ALU, 01 load data, 10 PC+4, 11 ALU
//  ALUResultW   in   XLEN   ALU result
//  ReadDataW    in   XLEN   load data
//  RdW          in   5      destination register index
//  PCPlus4W     in   XLEN   link value for JAL/JALR
//  Rs1D         in   5      decode read index, port 1
//  Rs2D         in   5      decode read index, port 2
//  RD1D         out  XLEN   read data, port 1
//  RD2D         out  XLEN   read data, port 2
//  ResultW      out  XLEN   selected writeback value (forwarding source)
//  WbCount      out  CNT_W  number of committed architectural writes
// BEHAVIOUR
//  - Reset (async, any time incl. mid-write): all NREGS registers -> 0, WbCount -> 0.
//    RD1D/RD2D therefore read 0 while reset is high; the write in that cycle is dropped.
//  - ResultW is combinational from ResultSrcW: 00/11 ALUResultW, 01 ReadDataW,
//    10 PCPlus4W. Zero-latency; independent of RegWriteW.
//  - Commit: at posedge, if RegWriteW && RdW != 0 then reg[RdW] <= ResultW and
//    WbCount <= WbCount + 1. Otherwise no state changes.
//  - x0: reads always return 0; writes to RdW==0 are discarded and do NOT count.
//  - Reads are combinational. Write-through bypass: if RegWriteW && RdW != 0 &&
//    RsND == RdW, RDND = ResultW (new value visible in the same cycle as the write).
//    Rs1D == Rs2D == RdW bypasses both ports identically.
//  - Read-after-commit: value is from the register array from the next cycle on.
//  - WbCount wraps modulo 2^CNT_W (all-ones + 1 -> 0), no saturation, no flag.
//  - No X propagation: unknown ResultSrcW codes map to ALUResultW.
//  - No stall/flush inputs: MEM/WB delivers bubbles as RegWriteW = 0.
// STRUCTURE
//  - Shared package: ResultSrc encodings (RES_ALU=2'b00, RES_MEM=2'b01,
//    RES_PC4=2'b10), XLEN default, register index width.
//  - One sub-module: regfile_2r1w (array, async reset, x0 handling, bypass).
//    Result mux and WbCount live in wb_regfile top.
// TESTING
//  1 Reset then read all 32 regs via Rs1D/Rs2D -> all 0; WbCount = 0.
//  2 RegWriteW=1, RdW=5, ResultSrcW=00, ALUResultW=32'hDEADBEEF; next cycle
//    Rs1D=5 -> RD1D=32'hDEADBEEF, WbCount=1.
//  3 ResultSrcW=01/10 with ReadDataW=32'h1234, PCPlus4W=32'h104 -> ResultW
//    follows; RdW=7 commits 32'h1234 then 32'h104.
//  4 Bypass: RegWriteW=1, RdW=9, ALU=32'hA5A5A5A5, Rs1D=Rs2D=9 in same cycle ->
//    RD1D=RD2D=32'hA5A5A5A5 combinationally.
//  5 RegWriteW=1, RdW=0, ALU=32'hFFFFFFFF -> Rs1D=0 reads 0, bypass off,
//    WbCount unchanged.
//  6 Preload WbCount to 32'hFFFFFFFF via 2^32-1 writes (or force), one write ->
//    WbCount=0; assert reset mid-cycle during a write -> reg and counter 0.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// Shared writeback definitions: result-select encodings, default widths.
// Combinational helpers only; no latency, no backpressure.
package wb_regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int REG_IDX_W = $clog2(NREGS_DEF);
    localparam int CNT_W_DEF = 32;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } res_src_e;

endpackage

// File: rtl/regfile_2r1w.sv
// 2-read/1-write register file, x0 hardwired to 0, write-through bypass to reads.
// Reads combinational, write commits at posedge; no backpressure.
module regfile_2r1w
    import wb_regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int IDX_W = $clog2(NREGS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [XLEN-1:0]  i_wr_dat,
    input  logic [IDX_W-1:0] i_rd1_idx,
    input  logic [IDX_W-1:0] i_rd2_idx,
    output logic [XLEN-1:0]  o_rd1_dat,
    output logic [XLEN-1:0]  o_rd2_dat,
    output logic             o_commit
);

    logic [XLEN-1:0] r_regs [NREGS];
    logic            w_we;

    // Gating with reset keeps the bypass from leaking a value that will be dropped.
    assign w_we     = i_wr_en && (i_wr_idx != '0) && !reset;
    assign o_commit = w_we;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_we) begin
            r_regs[i_wr_idx] <= i_wr_dat;
        end
    end

    always_comb begin
        o_rd1_dat = '0;
        if (i_rd1_idx != '0) begin
            o_rd1_dat = (w_we && i_rd1_idx == i_wr_idx) ? i_wr_dat : r_regs[i_rd1_idx];
        end
    end

    always_comb begin
        o_rd2_dat = '0;
        if (i_rd2_idx != '0) begin
            o_rd2_dat = (w_we && i_rd2_idx == i_wr_idx) ? i_wr_dat : r_regs[i_rd2_idx];
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: selects ResultW, commits it to the register file, counts commits.
// ResultW and reads are zero-latency; commit at posedge; no backpressure (bubbles are RegWriteW=0).
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     RegWriteW,
    input  logic [1:0]               ResultSrcW,
    input  logic [XLEN-1:0]          ALUResultW,
    input  logic [XLEN-1:0]          ReadDataW,
    input  logic [$clog2(NREGS)-1:0] RdW,
    input  logic [XLEN-1:0]          PCPlus4W,
    input  logic [$clog2(NREGS)-1:0] Rs1D,
    input  logic [$clog2(NREGS)-1:0] Rs2D,
    output logic [XLEN-1:0]          RD1D,
    output logic [XLEN-1:0]          RD2D,
    output logic [XLEN-1:0]          ResultW,
    output logic [CNT_W-1:0]         WbCount
);

    localparam int IDX_W = $clog2(NREGS);

    logic [CNT_W-1:0] r_wb_count;
    logic             w_commit;

    // Code 11 and any unknown code fall back to the ALU result.
    always_comb begin
        ResultW = ALUResultW;
        case (res_src_e'(ResultSrcW))
            RES_MEM: ResultW = ReadDataW;
            RES_PC4: ResultW = PCPlus4W;
            default: ResultW = ALUResultW;
        endcase
    end

    regfile_2r1w #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .IDX_W (IDX_W)
    ) u_regfile (
        .clock     (clock),
        .reset     (reset),
        .i_wr_en   (RegWriteW),
        .i_wr_idx  (RdW),
        .i_wr_dat  (ResultW),
        .i_rd1_idx (Rs1D),
        .i_rd2_idx (Rs2D),
        .o_rd1_dat (RD1D),
        .o_rd2_dat (RD2D),
        .o_commit  (w_commit)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wb_count <= '0;
        end else if (w_commit) begin
            r_wb_count <= r_wb_count + 1'b1;
        end
    end

    assign WbCount = r_wb_count;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile; a second instance with a 3-bit counter exercises wrap.
module tb_wb_regfile;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        RegWriteW = 1'b0;
    logic [1:0]  ResultSrcW = 2'b00;
    logic [31:0] ALUResultW = '0;
    logic [31:0] ReadDataW = '0;
    logic [4:0]  RdW = '0;
    logic [31:0] PCPlus4W = '0;
    logic [4:0]  Rs1D = '0;
    logic [4:0]  Rs2D = '0;
    logic [31:0] RD1D, RD2D, ResultW, WbCount;
    logic [31:0] rd1_c, rd2_c, res_c;
    logic [2:0]  cnt_c;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    wb_regfile dut (
        .clock(clock), .reset(reset), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
        .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .RdW(RdW), .PCPlus4W(PCPlus4W),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RD1D(RD1D), .RD2D(RD2D), .ResultW(ResultW),
        .WbCount(WbCount)
    );

    wb_regfile #(.CNT_W(3)) dut_c (
        .clock(clock), .reset(reset), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
        .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .RdW(RdW), .PCPlus4W(PCPlus4W),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RD1D(rd1_c), .RD2D(rd2_c), .ResultW(res_c),
        .WbCount(cnt_c)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // Every register reads 0 after reset
        for (int i = 0; i < 32; i++) begin
            Rs1D = 5'(i);
            Rs2D = 5'(31 - i);
            #1;
            chk($sformatf("rst_rd1_%0d", i), RD1D, 32'h0);
            chk($sformatf("rst_rd2_%0d", 31 - i), RD2D, 32'h0);
        end
        chk("rst_cnt", WbCount, 32'h0);

        // ALU write to x5
        RegWriteW = 1'b1; RdW = 5'd5; ResultSrcW = 2'b00; ALUResultW = 32'hDEADBEEF;
        ReadDataW = 32'h1234; PCPlus4W = 32'h104; Rs1D = 5'd0; Rs2D = 5'd0;
        #1 chk("res_alu", ResultW, 32'hDEADBEEF);
        tick();
        RegWriteW = 1'b0; Rs1D = 5'd5;
        #1 chk("rd_x5", RD1D, 32'hDEADBEEF);
        chk("cnt_1", WbCount, 32'd1);

        // Load-data and PC+4 selects committed to x7
        ResultSrcW = 2'b01; RdW = 5'd7; RegWriteW = 1'b1;
        #1 chk("res_mem", ResultW, 32'h1234);
        tick();
        RegWriteW = 1'b0; Rs2D = 5'd7;
        #1 chk("rd_x7_mem", RD2D, 32'h1234);
        chk("cnt_2", WbCount, 32'd2);
        ResultSrcW = 2'b10; RegWriteW = 1'b1;
        #1 chk("res_pc4", ResultW, 32'h104);
        tick();
        RegWriteW = 1'b0;
        #1 chk("rd_x7_pc4", RD2D, 32'h104);
        chk("cnt_3", WbCount, 32'd3);
        ResultSrcW = 2'b11;
        #1 chk("res_11_alu", ResultW, 32'hDEADBEEF);

        // Same-cycle bypass on both ports
        ResultSrcW = 2'b00; ALUResultW = 32'hA5A5A5A5; RdW = 5'd9; RegWriteW = 1'b1;
        Rs1D = 5'd9; Rs2D = 5'd9;
        #1 chk("byp_rd1", RD1D, 32'hA5A5A5A5);
        chk("byp_rd2", RD2D, 32'hA5A5A5A5);
        chk("byp_cnt_pre", WbCount, 32'd3);
        tick();
        RegWriteW = 1'b0;
        #1 chk("rd_x9", RD1D, 32'hA5A5A5A5);
        chk("cnt_4", WbCount, 32'd4);

        // No bypass without write enable
        ALUResultW = 32'h0BAD0BAD; RdW = 5'd5; Rs1D = 5'd5;
        #1 chk("nobyp_we0", RD1D, 32'hDEADBEEF);

        // x0 writes are discarded and uncounted
        ALUResultW = 32'hFFFFFFFF; RdW = 5'd0; RegWriteW = 1'b1; Rs1D = 5'd0; Rs2D = 5'd0;
        #1 chk("x0_rd1", RD1D, 32'h0);
        chk("x0_rd2", RD2D, 32'h0);
        tick();
        RegWriteW = 1'b0;
        #1 chk("x0_cnt", WbCount, 32'd4);
        chk("x0_rd_after", RD1D, 32'h0);

        // Counter wrap on the 3-bit instance: 4 -> 7 -> 0
        chk("c_cnt_4", {29'b0, cnt_c}, 32'd4);
        ALUResultW = 32'h11; RdW = 5'd10; RegWriteW = 1'b1;
        repeat (3) tick();
        RegWriteW = 1'b0;
        #1 chk("c_cnt_7", {29'b0, cnt_c}, 32'd7);
        RegWriteW = 1'b1;
        tick();
        RegWriteW = 1'b0; Rs1D = 5'd10;
        #1 chk("c_cnt_wrap", {29'b0, cnt_c}, 32'd0);
        chk("cnt_8", WbCount, 32'd8);
        chk("c_rd_x10", rd1_c, 32'h11);
        chk("c_res", res_c, 32'h11);
        chk("c_rd2_x0", rd2_c, 32'h0);

        // Reset asserted mid-cycle while a write is pending
        ALUResultW = 32'h55; RdW = 5'd12; RegWriteW = 1'b1; Rs1D = 5'd5; Rs2D = 5'd12;
        #2 reset = 1'b1;
        #1 chk("mid_rst_rd1", RD1D, 32'h0);
        chk("mid_rst_byp", RD2D, 32'h0);
        chk("mid_rst_cnt", WbCount, 32'h0);
        chk("mid_rst_res", ResultW, 32'h55);
        tick();
        RegWriteW = 1'b0;
        #1 reset = 1'b0;
        #1 chk("post_rst_x12", RD2D, 32'h0);
        chk("post_rst_x5", RD1D, 32'h0);
        chk("post_rst_cnt", WbCount, 32'h0);
        chk("post_rst_c_cnt", {29'b0, cnt_c}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
